// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding and mode constants for the left shifter
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic MODE_LOGICAL = 1'b0;
   localparam logic MODE_ROTATE  = 1'b1;

endpackage

// File: rtl/shl_step.sv
// rtl/shl_step.sv - combinational single-bit left step (logical or rotate)
// Overflow output only exists when SHL_OVERFLOW_FLAG_EN is defined.
module shl_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic             mode_i,
`ifdef SHL_OVERFLOW_FLAG_EN
   output logic             ovf_o,
`endif
   output logic [WIDTH-1:0] shifted_o
);

   logic fill_bit;

   // Rotate feeds the outgoing MSB back into bit 0; logical fills with zero.
   assign fill_bit  = (mode_i == MODE_ROTATE) ? value_i[WIDTH-1] : 1'b0;
   assign shifted_o = {value_i[WIDTH-2:0], fill_bit};

`ifdef SHL_OVERFLOW_FLAG_EN
   // Sign bit changes on this step: signed arithmetic-left overflow.
   assign ovf_o = (mode_i == MODE_LOGICAL) && (value_i[WIDTH-1] != value_i[WIDTH-2]);
`endif

endmodule

// File: rtl/seq_left_shifter.sv
// rtl/seq_left_shifter.sv - multi-cycle left shifter/rotator, one bit per clock
// Optional sticky overflow flag enabled by SHL_OVERFLOW_FLAG_EN.
module seq_left_shifter
   import shift_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               mode,
   input  logic [WIDTH-1:0]   in,
   input  logic [SHAMT_W-1:0] amount,
   output logic [WIDTH-1:0]   out,
   output logic               busy,
`ifdef SHL_OVERFLOW_FLAG_EN
   output logic               ovf,
`endif
   output logic               done
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic [SHAMT_W-1:0]   count_q, count_d;
   logic                 mode_q, mode_d;
   logic [WIDTH-1:0]     step_value;
`ifdef SHL_OVERFLOW_FLAG_EN
   logic                 ovf_q, ovf_d;
   logic                 step_ovf;
`endif

   shl_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .value_i   (out_q),
      .mode_i    (mode_q),
`ifdef SHL_OVERFLOW_FLAG_EN
      .ovf_o     (step_ovf),
`endif
      .shifted_o (step_value)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= '0;
         count_q <= '0;
         mode_q  <= MODE_LOGICAL;
`ifdef SHL_OVERFLOW_FLAG_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         count_q <= count_d;
         mode_q  <= mode_d;
`ifdef SHL_OVERFLOW_FLAG_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      count_d = count_q;
      mode_d  = mode_q;
`ifdef SHL_OVERFLOW_FLAG_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               out_d   = in;
               count_d = amount;
               mode_d  = mode;
`ifdef SHL_OVERFLOW_FLAG_EN
               ovf_d   = 1'b0;
`endif
               // A zero shift still passes through DONE so latency is amount+1.
               state_d = (amount != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            out_d   = step_value;
            count_d = count_q - SHAMT_W'(1);
`ifdef SHL_OVERFLOW_FLAG_EN
            ovf_d   = ovf_q | step_ovf;
`endif
            if (count_q == SHAMT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out  = out_q;
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
`ifdef SHL_OVERFLOW_FLAG_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_left_shifter.sv
// tb/tb_seq_left_shifter.sv - directed self-checking bench for seq_left_shifter
module tb_seq_left_shifter;

   logic       clk;
   logic       rst_n;
   logic       start_s;
   logic       mode_s;
   logic [3:0] in_s;
   logic [2:0] amount_s;
   logic [3:0] out_s;
   logic       busy_s;
   logic       done_s;
`ifdef SHL_OVERFLOW_FLAG_EN
   logic       ovf_s;
`endif

   int total;
   int bad;

   seq_left_shifter #(
      .WIDTH   (4),
      .SHAMT_W (3)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_s),
      .mode   (mode_s),
      .in     (in_s),
      .amount (amount_s),
      .out    (out_s),
      .busy   (busy_s),
`ifdef SHL_OVERFLOW_FLAG_EN
      .ovf    (ovf_s),
`endif
      .done   (done_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one start and observes 12 cycles; cycle c is sampled at the c-th falling edge.
   task automatic run_op(input logic [3:0] v, input logic [2:0] a, input logic m,
                         output int dcyc, output int nd, output int nb, output int both,
                         output logic [3:0] res, output logic ovf_seen);
      dcyc = 0; nd = 0; nb = 0; both = 0; res = 'x; ovf_seen = 1'b0;
      @(negedge clk);
      in_s = v; amount_s = a; mode_s = m; start_s = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start_s = 1'b0;
         if (done_s === 1'b1 && dcyc == 0) begin
            dcyc = c;
            res  = out_s;
`ifdef SHL_OVERFLOW_FLAG_EN
            ovf_seen = ovf_s;
`endif
         end
         if (done_s === 1'b1) nd++;
         if (busy_s === 1'b1) nb++;
         if (busy_s === 1'b1 && done_s === 1'b1) both++;
      end
   endtask

   task automatic test_reset();
      total++; if (out_s !== 4'b0000) begin bad++; $display("FAIL reset_out got=%b exp=0000", out_s); end
      total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_s); end
      total++; if (done_s !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_s); end
   endtask

   task automatic test_logical();
      int dcyc, nd, nb, both; logic [3:0] res; logic o;
      run_op(4'b1010, 3'd1, 1'b0, dcyc, nd, nb, both, res, o);
      total++; if (dcyc != 2) begin bad++; $display("FAIL shl1_latency got=%0d exp=2", dcyc); end
      total++; if (res !== 4'b0100) begin bad++; $display("FAIL shl1_out got=%b exp=0100", res); end
      total++; if (nb != 1) begin bad++; $display("FAIL shl1_busy_cycles got=%0d exp=1", nb); end
      total++; if (nd != 1) begin bad++; $display("FAIL shl1_done_pulses got=%0d exp=1", nd); end
      total++; if (both != 0) begin bad++; $display("FAIL shl1_busy_and_done got=%0d exp=0", both); end
   endtask

   task automatic test_rotate();
      int dcyc, nd, nb, both; logic [3:0] res; logic o;
      run_op(4'b1010, 3'd1, 1'b1, dcyc, nd, nb, both, res, o);
      total++; if (dcyc != 2) begin bad++; $display("FAIL rol1_latency got=%0d exp=2", dcyc); end
      total++; if (res !== 4'b0101) begin bad++; $display("FAIL rol1_out got=%b exp=0101", res); end
      run_op(4'b0011, 3'd5, 1'b1, dcyc, nd, nb, both, res, o);
      total++; if (dcyc != 6) begin bad++; $display("FAIL rol5_latency got=%0d exp=6", dcyc); end
      total++; if (res !== 4'b0110) begin bad++; $display("FAIL rol5_out got=%b exp=0110", res); end
      total++; if (nb != 5) begin bad++; $display("FAIL rol5_busy_cycles got=%0d exp=5", nb); end
      total++; if (both != 0) begin bad++; $display("FAIL rol5_busy_and_done got=%0d exp=0", both); end
   endtask

   task automatic test_amount_bounds();
      int dcyc, nd, nb, both; logic [3:0] res; logic o;
      run_op(4'b1010, 3'd0, 1'b0, dcyc, nd, nb, both, res, o);
      total++; if (dcyc != 1) begin bad++; $display("FAIL amt0_latency got=%0d exp=1", dcyc); end
      total++; if (res !== 4'b1010) begin bad++; $display("FAIL amt0_out got=%b exp=1010", res); end
      total++; if (nb != 0) begin bad++; $display("FAIL amt0_busy_cycles got=%0d exp=0", nb); end
      run_op(4'b1010, 3'd7, 1'b0, dcyc, nd, nb, both, res, o);
      total++; if (dcyc != 8) begin bad++; $display("FAIL amt7_latency got=%0d exp=8", dcyc); end
      total++; if (res !== 4'b0000) begin bad++; $display("FAIL amt7_out got=%b exp=0000", res); end
      total++; if (nb != 7) begin bad++; $display("FAIL amt7_busy_cycles got=%0d exp=7", nb); end
   endtask

   task automatic test_ignore_start();
      int dcyc = 0, nd = 0;
      logic [3:0] res = 'x;
      @(negedge clk);
      in_s = 4'b0001; amount_s = 3'd3; mode_s = 1'b0; start_s = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start_s = (c == 1);
         if (c == 1) begin
            in_s = 4'b1111; amount_s = 3'd1; mode_s = 1'b1;
         end
         if (done_s === 1'b1 && dcyc == 0) begin dcyc = c; res = out_s; end
         if (done_s === 1'b1) nd++;
      end
      total++; if (dcyc != 4) begin bad++; $display("FAIL ignore_latency got=%0d exp=4", dcyc); end
      total++; if (res !== 4'b1000) begin bad++; $display("FAIL ignore_out got=%b exp=1000", res); end
      total++; if (nd != 1) begin bad++; $display("FAIL ignore_done_pulses got=%0d exp=1", nd); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in_s = 4'b1010; amount_s = 3'd0; mode_s = 1'b0; start_s = 1'b1;
      @(negedge clk);
      total++; if (done_s !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", done_s); end
      in_s = 4'b0101;
      @(negedge clk);
      total++; if (done_s !== 1'b0) begin bad++; $display("FAIL b2b_start_in_done got=%b exp=0", done_s); end
      total++; if (out_s !== 4'b1010) begin bad++; $display("FAIL b2b_hold_out got=%b exp=1010", out_s); end
      @(negedge clk);
      start_s = 1'b0;
      total++; if (done_s !== 1'b1) begin bad++; $display("FAIL b2b_second_done got=%b exp=1", done_s); end
      total++; if (out_s !== 4'b0101) begin bad++; $display("FAIL b2b_second_out got=%b exp=0101", out_s); end
   endtask

   task automatic test_reset_abort();
      int dcyc, nd, nb, both; logic [3:0] res; logic o;
      int stray = 0;
      @(negedge clk);
      in_s = 4'b0001; amount_s = 3'd5; mode_s = 1'b1; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      @(negedge clk);
      total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", busy_s); end
      rst_n = 1'b0;
      #1;
      total++; if (out_s !== 4'b0000) begin bad++; $display("FAIL abort_out got=%b exp=0000", out_s); end
      total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_s); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done_s !== 1'b0 || busy_s !== 1'b0) stray++;
      end
      total++; if (stray != 0) begin bad++; $display("FAIL abort_stray_activity got=%0d exp=0", stray); end
      run_op(4'b0001, 3'd2, 1'b0, dcyc, nd, nb, both, res, o);
      total++; if (dcyc != 3) begin bad++; $display("FAIL post_reset_latency got=%0d exp=3", dcyc); end
      total++; if (res !== 4'b0100) begin bad++; $display("FAIL post_reset_out got=%b exp=0100", res); end
   endtask

`ifdef SHL_OVERFLOW_FLAG_EN
   task automatic test_ovf();
      int dcyc, nd, nb, both; logic [3:0] res; logic o;
      run_op(4'b0110, 3'd1, 1'b0, dcyc, nd, nb, both, res, o);
      total++; if (res !== 4'b1100) begin bad++; $display("FAIL ovf_a_out got=%b exp=1100", res); end
      total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_a_flag got=%b exp=1", o); end
      run_op(4'b1110, 3'd1, 1'b0, dcyc, nd, nb, both, res, o);
      total++; if (res !== 4'b1100) begin bad++; $display("FAIL ovf_b_out got=%b exp=1100", res); end
      total++; if (o !== 1'b0) begin bad++; $display("FAIL ovf_b_flag got=%b exp=0", o); end
      run_op(4'b0110, 3'd1, 1'b1, dcyc, nd, nb, both, res, o);
      total++; if (res !== 4'b1100) begin bad++; $display("FAIL ovf_rot_out got=%b exp=1100", res); end
      total++; if (o !== 1'b0) begin bad++; $display("FAIL ovf_rot_flag got=%b exp=0", o); end
   endtask
`endif

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; start_s = 1'b0; mode_s = 1'b0; in_s = '0; amount_s = '0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_logical();
      test_rotate();
      test_amount_bounds();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
`ifdef SHL_OVERFLOW_FLAG_EN
      test_ovf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
